// File: rtl/fetch_decode_queue_pkg.sv
// Shared widths and entry bundle for the fetch/decode queue.
// Entry = {instruction, pc, incremented_pc}, 160 bits total.
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif
`ifndef FDQ_ENTRY_W
`define FDQ_ENTRY_W (`INSTR_LEN + 2*`WORD)
`endif

package fetch_decode_queue_pkg;

   localparam int WORD_W  = `WORD;
   localparam int INSTR_W = `INSTR_LEN;
   localparam int ENTRY_W = `FDQ_ENTRY_W;

   typedef struct packed {
      logic [INSTR_W-1:0] instruction;
      logic [WORD_W-1:0]  pc;
      logic [WORD_W-1:0]  incremented_pc;
   } fdq_entry_t;

endpackage

// File: rtl/fetch_decode_queue_ram.sv
// DEPTH x ENTRY_W storage: sync write, async read, no reset.
// Ports: clk, we, waddr, wdata, raddr, rdata.
module queue_ram
   import fetch_decode_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               we,
   input  logic [PTR_W-1:0]   waddr,
   input  logic [ENTRY_W-1:0] wdata,
   input  logic [PTR_W-1:0]   raddr,
   output logic [ENTRY_W-1:0] rdata
);

   logic [ENTRY_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// In-order Fetch->Decode instruction queue with one-cycle flush.
// Ports: clk, reset (async low), flush, in_* / out_* handshakes, count.
module fetch_decode_queue
   import fetch_decode_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [INSTR_W-1:0]   in_instruction,
   input  logic [WORD_W-1:0]    in_pc,
   input  logic [WORD_W-1:0]    in_incremented_pc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [INSTR_W-1:0]   out_instruction,
   output logic [WORD_W-1:0]    out_pc,
   output logic [WORD_W-1:0]    out_incremented_pc,
   output logic [PTR_W:0]       count
);

   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;
   fdq_entry_t       wr_entry;
   fdq_entry_t       rd_entry;
   fdq_entry_t       head;

   assign in_ready  = reset & (count < FULL);
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   assign wr_entry.instruction    = in_instruction;
   assign wr_entry.pc             = in_pc;
   assign wr_entry.incremented_pc = in_incremented_pc;

   queue_ram #(.DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .raddr (rd_ptr),
      .rdata (rd_entry)
   );

   // Empty queue shows an all-zero entry, never stale storage.
   assign head = out_valid ? rd_entry : '0;

   assign out_instruction    = head.instruction;
   assign out_pc             = head.pc;
   assign out_incremented_pc = head.incremented_pc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case (1'b1)
            (push & ~pop): count <= count + 1'b1;
            (pop & ~push): count <= count - 1'b1;
            default:       count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue (DEPTH=4).
// Checks reset, fill/wrap, push+pop, flush and async reset.
module tb_fetch_decode_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instruction;
   logic [63:0] in_pc;
   logic [63:0] in_incremented_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instruction;
   logic [63:0] out_pc;
   logic [63:0] out_incremented_pc;
   logic [2:0]  count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fetch_decode_queue #(.DEPTH(4)) dut (
      .clk                (clk),
      .reset              (reset),
      .flush              (flush),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .in_instruction     (in_instruction),
      .in_pc              (in_pc),
      .in_incremented_pc  (in_incremented_pc),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .out_instruction    (out_instruction),
      .out_pc             (out_pc),
      .out_incremented_pc (out_incremented_pc),
      .count              (count)
   );

   task automatic check(
      input string       tag,
      input logic [63:0] got,
      input logic [63:0] exp
   );
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [63:0] pc);
      in_valid          = 1'b1;
      in_instruction    = 32'h1000_0000 | pc[31:0];
      in_pc             = pc;
      in_incremented_pc = pc + 64'd4;
   endtask

   task automatic push(input logic [63:0] pc);
      drive(pc);
      step();
      in_valid = 1'b0;
   endtask

   task automatic pop_check(input logic [63:0] pc);
      check("head_valid", 64'(out_valid), 64'd1);
      check("head_pc", out_pc, pc);
      check("head_instr", 64'(out_instruction),
            64'(32'h1000_0000 | pc[31:0]));
      check("head_inc", out_incremented_pc, pc + 64'd4);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      reset             = 1'b0;
      flush             = 1'b0;
      in_valid          = 1'b0;
      out_ready         = 1'b0;
      in_instruction    = '0;
      in_pc             = '0;
      in_incremented_pc = '0;

      // Reset then idle
      step();
      step();
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_ready", 64'(in_ready), 64'd0);
      reset = 1'b1;
      #1;
      check("idle_ready", 64'(in_ready), 64'd1);
      check("idle_instr", 64'(out_instruction), 64'd0);
      step();
      check("idle_count", 64'(count), 64'd0);

      // Single pass
      in_valid          = 1'b1;
      in_instruction    = 32'h8B02_0020;
      in_pc             = 64'd0;
      in_incremented_pc = 64'd4;
      step();
      in_valid = 1'b0;
      check("sp_valid", 64'(out_valid), 64'd1);
      check("sp_pc", out_pc, 64'd0);
      check("sp_inc", out_incremented_pc, 64'd4);
      check("sp_instr", 64'(out_instruction),
            64'h8B02_0020);
      check("sp_count", 64'(count), 64'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("sp_count0", 64'(count), 64'd0);
      check("sp_valid0", 64'(out_valid), 64'd0);
      check("sp_instr0", 64'(out_instruction), 64'd0);

      // Fill, overflow attempt, drain, wrap
      for (int i = 0; i < 4; i++) push(64'(4 * i));
      check("full_count", 64'(count), 64'd4);
      check("full_ready", 64'(in_ready), 64'd0);
      push(64'd16);
      check("ovf_count", 64'(count), 64'd4);
      check("ovf_head", out_pc, 64'd0);
      for (int i = 0; i < 4; i++) pop_check(64'(4 * i));
      check("drain_count", 64'(count), 64'd0);
      for (int i = 0; i < 4; i++) push(64'(20 + 4 * i));
      for (int i = 0; i < 4; i++) pop_check(64'(20 + 4 * i));
      check("wrap_count", 64'(count), 64'd0);

      // Simultaneous push and pop at count=2
      push(64'd40);
      push(64'd44);
      drive(64'd48);
      out_ready = 1'b1;
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("pp_count", 64'(count), 64'd2);
      pop_check(64'd44);
      pop_check(64'd48);
      check("pp_empty", 64'(out_valid), 64'd0);

      // Flush beats push and pop
      push(64'd60);
      push(64'd64);
      push(64'd68);
      check("fl_pre", 64'(count), 64'd3);
      drive(64'd100);
      out_ready = 1'b1;
      flush     = 1'b1;
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
      check("fl_count", 64'(count), 64'd0);
      check("fl_valid", 64'(out_valid), 64'd0);
      check("fl_ready", 64'(in_ready), 64'd1);
      push(64'd200);
      check("fl_head", out_pc, 64'd200);
      check("fl_count1", 64'(count), 64'd1);

      // Async reset between edges
      push(64'd204);
      push(64'd208);
      check("ar_pre", 64'(count), 64'd3);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("ar_valid", 64'(out_valid), 64'd0);
      check("ar_count", 64'(count), 64'd0);
      check("ar_pc", out_pc, 64'd0);
      check("ar_ready", 64'(in_ready), 64'd0);
      step();
      reset = 1'b1;
      step();

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
Instruction queue between the Fetch stage and the Decode stage.
- Accepts {instruction, pc, incremented_pc} triples from Fetch using a valid/ready handshake.
- Buffers up to DEPTH entries and presents them to Decode in order, so a Decode stall does not lose fetched instructions.
- A branch redirect discards all buffered entries in one cycle.

Parameters:
DEPTH, 4, number of entries; must be a power of 2 and >= 2
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
flush  input  1  branch redirect (pc_src != 0); discards all entries
in_valid  input  1  Fetch presents an entry
in_ready  output  1  queue can accept an entry this cycle
in_instruction  input  `INSTR_LEN  fetched instruction
in_pc  input  `WORD  PC of the instruction
in_incremented_pc  input  `WORD  PC+4
out_valid  output  1  head entry valid for Decode
out_ready  input  1  Decode consumes head this cycle
out_instruction  output  `INSTR_LEN  head instruction
out_pc  output  `WORD  head PC
out_incremented_pc  output  `WORD  head PC+4
count  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (reset=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, out_valid=0, and all out_* data are 0. in_ready=0 while reset is low. Storage contents are not reset.
- Handshakes:
  - push = in_valid & in_ready & ~flush
  - pop = out_valid & out_ready & ~flush
- Ready and valid:
  - in_ready = reset & (count < DEPTH), combinational, and independent of out_ready. There is no same-cycle pass-through when full.
  - out_valid = (count != 0).
- Output data: out_* are read combinationally from entry[rd_ptr] when count != 0. Otherwise out_* are forced to 0 (all-zero instruction).
- Latency: an entry pushed at edge k appears on out_* with out_valid=1 immediately after edge k. There is no same-cycle bypass from in_* to out_*, even when the queue is empty.
- Push only: entry[wr_ptr] <= {in_instruction, in_pc, in_incremented_pc}; wr_ptr++; count++.
- Pop only: rd_ptr++; count--.
- Push and pop in the same cycle: both pointers advance and count is unchanged. This is legal at any count from 1 to DEPTH-1.
- Pointer wrap: pointers are PTR_W bits and wrap DEPTH-1 -> 0 naturally. count is tracked separately to distinguish full from empty.
- Flush (synchronous, highest priority below reset): at the next edge, wr_ptr=0, rd_ptr=0, count=0.
  - Any push or pop in that cycle is ignored.
  - out_valid falls right after the edge.
  - in_ready stays 1, so Fetch may push the redirect-target instruction in the following cycle.
- Overflow and underflow are impossible by construction. in_valid while full and out_ready while empty are no-ops.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge. Entries buffered at that point are lost.

Decomposition:
- `WORD (64) and `INSTR_LEN (32) come from constants.vh.
- Add `FDQ_ENTRY_W = `INSTR_LEN + 2*`WORD (160) to constants.vh.
- Sub-module queue_ram:
  - DEPTH x `FDQ_ENTRY_W register array.
  - One synchronous write port (clk, we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
  - No reset.
- Pointer, count and flush control stay in fetch_decode_queue.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then 1 -> out_valid=0, count=0, out_instruction=0, in_ready=1 after release.
- Single pass: push {instr=32'h8B020020, pc=0, inc=4} with out_ready=0 -> next cycle out_valid=1, out_pc=0, count=1. Then out_ready=1 for one cycle -> count=0, out_valid=0.
- Fill and wrap: push 4 entries (pc=0,4,8,12) with out_ready=0 -> count=4, in_ready=0; a 5th push (pc=16) is ignored. Pop all four, then push pc=20..32 -> popped order is 0,4,8,12,20,24,28,32 and both pointers wrap.
- Simultaneous push/pop at count=2 -> count stays 2 and the order is preserved.
- Flush: with count=3, assert flush together with in_valid (pc=100) and out_ready -> next cycle count=0, out_valid=0, and pc=100 is not stored. Pushing pc=200 next cycle makes it the head.
- Async reset mid-stream: count=3, drop reset between clock edges -> out_valid=0 and count=0 before the next edge.
